// File: rtl/crc_engine_param_if.sv
// crc_engine_param_if
//   Operand/handshake bundle between the CRC extension's decode/execute
//   logic (master) and crc_engine_param (slave).
//   Signals:
//     crc_reset  master->slave  load INIT into the CRC register
//     start      master->slave  begin an operation (honoured in IDLE only)
//     data_in    master->slave  operand, byte 0 = data_in[7:0], consumed first
//     nbytes     master->slave  number of valid low bytes, 0..DATA_BYTES
//     busy       slave->master  operation in progress, requester must stall
//     done       slave->master  one-cycle pulse when crc_out has been updated
//     crc_out    slave->master  crc register ^ FINAL_XOR
interface crc_engine_param_if #(
  parameter int unsigned CRC_WIDTH  = 32,
  parameter int unsigned DATA_BYTES = 4
);
  localparam int unsigned NB_W = $clog2(DATA_BYTES + 1);

  logic                    crc_reset;
  logic                    start;
  logic [DATA_BYTES*8-1:0] data_in;
  logic [NB_W-1:0]         nbytes;
  logic                    busy;
  logic                    done;
  logic [CRC_WIDTH-1:0]    crc_out;

  modport master (
    output crc_reset, start, data_in, nbytes,
    input  busy, done, crc_out
  );

  modport slave (
    input  crc_reset, start, data_in, nbytes,
    output busy, done, crc_out
  );
endinterface

// File: rtl/crc_engine_param.sv
// crc_engine_param
//   Parametrised multi-cycle CRC execution unit. Folds BITS_PER_CYCLE
//   operand bits into the CRC register per clock; an operation of nbytes
//   bytes takes nbytes*8/BITS_PER_CYCLE busy cycles and done pulses in the
//   cycle after the last step.
//   Ports:
//     CLK  in  clock, rising edge
//     RST  in  asynchronous active-high reset
//     bus  crc_engine_param_if.slave (crc_reset/start/data_in/nbytes in,
//          busy/done/crc_out out)
//   Build option:
//     CRC_REFLECT_EN defined   -> reflected CRC (bits LSB-first, reversed
//                                 polynomial); defaults give CRC-32/zlib.
//     CRC_REFLECT_EN undefined -> normal MSB-first CRC; defaults give
//                                 CRC-32/BZIP2.
module crc_engine_param #(
  parameter int unsigned CRC_WIDTH      = 32,
  parameter logic [31:0] POLY           = 32'h04C11DB7,
  parameter logic [31:0] INIT           = 32'hFFFFFFFF,
  parameter logic [31:0] FINAL_XOR      = 32'hFFFFFFFF,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic              CLK,
  input  logic              RST,
  crc_engine_param_if.slave bus
);

  localparam int unsigned DW             = DATA_BYTES * 8;
  localparam int unsigned STEPS_PER_BYTE = 8 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W          = $clog2(DW / BITS_PER_CYCLE + 1);

  localparam logic [CRC_WIDTH-1:0] POLY_W = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT_W = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] FXOR_W = FINAL_XOR[CRC_WIDTH-1:0];

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("crc_engine_param: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  if (CRC_WIDTH < 8 || CRC_WIDTH > 32) begin : g_bad_width
    $error("crc_engine_param: CRC_WIDTH must be 8..32");
  end

`ifdef CRC_REFLECT_EN
  function automatic logic [CRC_WIDTH-1:0] bitrev_w(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [CRC_WIDTH-1:0] POLY_REV = bitrev_w(POLY_W);

  // Reflected order already consumes bit 0 of each byte first.
  function automatic logic [DW-1:0] order_bits(input logic [DW-1:0] d);
    return d;
  endfunction
`else
  // Normal order wants each byte MSB-first. Reversing the bits inside every
  // byte at latch time lets both builds consume the operand register from
  // bit 0 upward with a plain right shift.
  function automatic logic [DW-1:0] order_bits(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++)
      for (int unsigned j = 0; j < 8; j++)
        r[k*8+j] = d[k*8+7-j];
    return r;
  endfunction
`endif

  // BITS_PER_CYCLE single-bit LFSR steps unrolled; bits[0] is folded first.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0]      c,
    input logic [BITS_PER_CYCLE-1:0] bits
  );
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = c;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef CRC_REFLECT_EN
      fb = r[0] ^ bits[i];
      r  = (r >> 1) ^ (fb ? POLY_REV : '0);
`else
      fb = r[CRC_WIDTH-1] ^ bits[i];
      r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
`endif
    end
    return r;
  endfunction

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [DW-1:0]        data_q, data_d;
  logic [CNT_W-1:0]     steps_q, steps_d;
  logic                 done_q, done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      crc_q   <= INIT_W;
      data_q  <= '0;
      steps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      steps_q <= steps_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    data_d  = data_q;
    steps_d = steps_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // crc_reset takes effect before a same-cycle start; the first step
        // then runs from INIT in the following cycle.
        if (bus.crc_reset) crc_d = INIT_W;
        if (bus.start) begin
          if (bus.nbytes == '0) begin
            done_d = 1'b1;
          end else begin
            data_d  = order_bits(bus.data_in);
            steps_d = CNT_W'(bus.nbytes * STEPS_PER_BYTE);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.crc_reset) begin
          crc_d   = INIT_W;
          steps_d = '0;
          state_d = S_IDLE;
        end else begin
          crc_d   = crc_step(crc_q, data_q[BITS_PER_CYCLE-1:0]);
          data_d  = data_q >> BITS_PER_CYCLE;
          steps_d = steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q == S_BUSY);
  assign bus.done    = done_q;
  assign bus.crc_out = crc_q ^ FXOR_W;

endmodule
